// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU normaliser.
//   FPU_EW   : exponent width (two's complement)
//   FPU_MW   : mantissa width including the implicit bit
//   FPU_EMIN : minimum unbiased exponent
//   norm_state_t : normaliser FSM states
package fpu_pkg;

    localparam int FPU_EW   = 10;
    localparam int FPU_MW   = 24;
    localparam int FPU_EMIN = -126;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        NORM_L,
        NORM_R,
        DONE
    } norm_state_t;

endpackage

// File: rtl/fpu_norm_step.sv
// Single-step shifter for the normaliser datapath (purely combinational).
//   dir_right : 1 = shift right one place (e+1), 0 = shift left one place (e-1)
//   e_in/m_in/g_in/r_in/s_in : current exponent, mantissa (with carry bit), G/R/S
//   e_out/m_out/g_out/r_out/s_out : values after the step
// A right step moves m[0] into guard, guard into round and ORs round into sticky.
// A left step pulls guard into m[0] and round into guard; sticky is untouched.
module fpu_norm_step #(
    parameter int EW = 10,
    parameter int MW = 24
) (
    input  logic          dir_right,
    input  logic [EW-1:0] e_in,
    input  logic [MW:0]   m_in,
    input  logic          g_in,
    input  logic          r_in,
    input  logic          s_in,
    output logic [EW-1:0] e_out,
    output logic [MW:0]   m_out,
    output logic          g_out,
    output logic          r_out,
    output logic          s_out
);

    always_comb begin
        if (dir_right) begin
            m_out = m_in >> 1;
            e_out = e_in + EW'(1);
            g_out = m_in[0];
            r_out = g_in;
            s_out = s_in | r_in;
        end else begin
            // Only used once any carry has been shifted out, so m[MW] is 0 here.
            m_out = {m_in[MW-1:0], g_in};
            e_out = e_in - EW'(1);
            g_out = r_in;
            r_out = 1'b0;
            s_out = s_in;
        end
    end

endmodule

// File: rtl/fpu_normalise.sv
// Iterative normaliser in front of the FPU rounding stage. Shifts one bit per
// cycle until the mantissa is normalised or the exponent reaches EMIN.
// Ports:
//   clk, rst (async, active high)
//   in_valid/in_ready   : operand handshake (accepted only in IDLE)
//   e_in, m_in, guard_in, round_in, sticky_in : raw operand, m_in[MW] = carry
//   out_valid/out_ready : result handshake (result held in DONE)
//   z_e_out, z_m_out, guard_out, round_out, sticky_out : normalised result,
//     z_m_out = {3'b0, mantissa[MW-1:0]}
// Optional build: FPU_NORM_CYCLE_COUNT_EN adds norm_cycles[9:0], the number of
// NORM_L + NORM_R shift steps of the current operation.
//
// state  | meaning
// IDLE   | waiting for an operand, in_ready=1
// PRE    | zero detect / carry right shift
// NORM_L | left shifts until implicit bit set or e==EMIN
// NORM_R | right shifts until e>=EMIN
// DONE   | result valid, held until out_ready
module fpu_normalise
    import fpu_pkg::*;
#(
    parameter int EW   = FPU_EW,
    parameter int MW   = FPU_MW,
    parameter int EMIN = FPU_EMIN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [EW-1:0] e_in,
    input  logic [MW:0]   m_in,
    input  logic          guard_in,
    input  logic          round_in,
    input  logic          sticky_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [EW-1:0] z_e_out,
    output logic [26:0]   z_m_out,
    output logic          guard_out,
    output logic          round_out,
    output logic          sticky_out
`ifdef FPU_NORM_CYCLE_COUNT_EN
   ,output logic [9:0]    norm_cycles
`endif
);

    localparam logic [EW-1:0] EMIN_E = EW'(EMIN);

    norm_state_t   state_q, state_d;
    logic [EW-1:0] e_q, e_d;
    logic [MW:0]   m_q, m_d;
    logic          g_q, g_d, r_q, r_d, s_q, s_d;

    logic          step_right, step_take;
    logic [EW-1:0] st_e;
    logic [MW:0]   st_m;
    logic          st_g, st_r, st_s;

    fpu_norm_step #(.EW(EW), .MW(MW)) u_step (
        .dir_right (step_right),
        .e_in      (e_q),
        .m_in      (m_q),
        .g_in      (g_q),
        .r_in      (r_q),
        .s_in      (s_q),
        .e_out     (st_e),
        .m_out     (st_m),
        .g_out     (st_g),
        .r_out     (st_r),
        .s_out     (st_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            e_q     <= '0;
            m_q     <= '0;
            g_q     <= 1'b0;
            r_q     <= 1'b0;
            s_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            m_q     <= m_d;
            g_q     <= g_d;
            r_q     <= r_d;
            s_q     <= s_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        e_d        = e_q;
        m_d        = m_q;
        g_d        = g_q;
        r_d        = r_q;
        s_d        = s_q;
        step_right = 1'b0;
        step_take  = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    e_d     = e_in;
                    m_d     = m_in;
                    g_d     = guard_in;
                    r_d     = round_in;
                    s_d     = sticky_in;
                    state_d = PRE;
                end
            end
            PRE: begin
                if (m_q == '0 && !g_q && !r_q && !s_q) begin
                    // A zero result still passes through NORM_R, where e==EMIN
                    // means no step is taken, giving a fixed two-cycle latency.
                    e_d     = EMIN_E;
                    state_d = NORM_R;
                end else begin
                    if (m_q[MW]) begin
                        step_right = 1'b1;
                        step_take  = 1'b1;
                    end
                    state_d = NORM_L;
                end
            end
            NORM_L: begin
                if (!m_q[MW-1] && ($signed(e_q) > $signed(EMIN_E))) begin
                    step_take = 1'b1;
                end else begin
                    state_d = NORM_R;
                end
            end
            NORM_R: begin
                if ($signed(e_q) < $signed(EMIN_E)) begin
                    step_right = 1'b1;
                    step_take  = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (step_take) begin
            e_d = st_e;
            m_d = st_m;
            g_d = st_g;
            r_d = st_r;
            s_d = st_s;
        end
    end

    assign z_e_out    = e_q;
    assign z_m_out    = {{(27-MW){1'b0}}, m_q[MW-1:0]};
    assign guard_out  = g_q;
    assign round_out  = r_q;
    assign sticky_out = s_q;

`ifdef FPU_NORM_CYCLE_COUNT_EN
    logic [9:0] cnt_q;

    // The carry shift in PRE is not a normalisation step and is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == IDLE && in_valid) begin
            cnt_q <= '0;
        end else if (step_take && (state_q == NORM_L || state_q == NORM_R)) begin
            cnt_q <= cnt_q + 10'd1;
        end
    end

    assign norm_cycles = cnt_q;
`endif

endmodule

// File: tb/tb_fpu_normalise.sv
module tb_fpu_normalise;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  e_in;
    logic [24:0] m_in;
    logic        guard_in, round_in, sticky_in;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  z_e_out;
    logic [26:0] z_m_out;
    logic        guard_out, round_out, sticky_out;

    int checks = 0;
    int errors = 0;

    logic [9:0]  o_e;
    logic [26:0] o_m;
    logic        o_g, o_r, o_s;
    int          lat;

    fpu_normalise dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .e_in       (e_in),
        .m_in       (m_in),
        .guard_in   (guard_in),
        .round_in   (round_in),
        .sticky_in  (sticky_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .z_e_out    (z_e_out),
        .z_m_out    (z_m_out),
        .guard_out  (guard_out),
        .round_out  (round_out),
        .sticky_out (sticky_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operand and waits (bounded) for out_valid; lat = -1 on timeout.
    task automatic apply_op(input logic [9:0] e, input logic [24:0] m,
                            input logic g, input logic r, input logic s);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        e_in = e; m_in = m; guard_in = g; round_in = r; sticky_in = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 500) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) lat = -1;
        o_e = z_e_out; o_m = z_m_out; o_g = guard_out; o_r = round_out; o_s = sticky_out;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
        end
        checks++;
        if (z_e_out !== 10'd0 || z_m_out !== 27'd0 || {guard_out, round_out, sticky_out} !== 3'b000) begin
            errors++;
            $display("FAIL reset_data: e=%h m=%h grs=%b%b%b, want all 0",
                     z_e_out, z_m_out, guard_out, round_out, sticky_out);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_left_one();
        apply_op(10'd0, 25'h0400000, 1'b1, 1'b0, 1'b0);
        checks++;
        if (o_e !== 10'h3FF || o_m !== 27'h0800001 || {o_g, o_r, o_s} !== 3'b000) begin
            errors++;
            $display("FAIL left_one: e=%h m=%h grs=%b%b%b, want e=3ff m=800001 grs=000", o_e, o_m, o_g, o_r, o_s);
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL left_one_latency: got %0d, want 4", lat);
        end
        release_result();
    endtask

    task automatic test_carry();
        apply_op(10'd5, 25'h1800000, 1'b1, 1'b1, 1'b0);
        checks++;
        if (o_e !== 10'd6 || o_m !== 27'h0C00000 || {o_g, o_r, o_s} !== 3'b011) begin
            errors++;
            $display("FAIL carry: e=%h m=%h grs=%b%b%b, want e=006 m=c00000 grs=011", o_e, o_m, o_g, o_r, o_s);
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL carry_latency: got %0d, want 3", lat);
        end
        release_result();
    endtask

    task automatic test_subnormal_right();
        apply_op(-10'sd128, 25'h0800003, 1'b0, 1'b0, 1'b0);
        checks++;
        if (o_e !== 10'h382 || o_m !== 27'h0200000 || {o_g, o_r, o_s} !== 3'b110) begin
            errors++;
            $display("FAIL right_two: e=%h m=%h grs=%b%b%b, want e=382 m=200000 grs=110", o_e, o_m, o_g, o_r, o_s);
        end
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL right_two_latency: got %0d, want 5", lat);
        end
        release_result();
    endtask

    task automatic test_zero();
        apply_op(10'd40, 25'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (o_e !== 10'h382 || o_m !== 27'h0 || {o_g, o_r, o_s} !== 3'b000) begin
            errors++;
            $display("FAIL zero: e=%h m=%h grs=%b%b%b, want e=382 m=0 grs=000", o_e, o_m, o_g, o_r, o_s);
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL zero_latency: got %0d, want 2", lat);
        end
        release_result();
    endtask

    task automatic test_emin_stop();
        apply_op(-10'sd125, 25'h0100000, 1'b1, 1'b0, 1'b0);
        checks++;
        if (o_e !== 10'h382 || o_m !== 27'h0200001 || {o_g, o_r, o_s} !== 3'b000) begin
            errors++;
            $display("FAIL emin_stop: e=%h m=%h grs=%b%b%b, want e=382 m=200001 grs=000", o_e, o_m, o_g, o_r, o_s);
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL emin_stop_latency: got %0d, want 4", lat);
        end
        release_result();
    endtask

    // e=-200: 74 right steps, the lone mantissa bit ends up only in sticky.
    task automatic test_deep_underflow();
        apply_op(-10'sd200, 25'h0800000, 1'b0, 1'b0, 1'b0);
        checks++;
        if (o_e !== 10'h382 || o_m !== 27'h0 || {o_g, o_r, o_s} !== 3'b001) begin
            errors++;
            $display("FAIL deep_underflow: e=%h m=%h grs=%b%b%b, want e=382 m=0 grs=001", o_e, o_m, o_g, o_r, o_s);
        end
        checks++;
        if (lat !== 77) begin
            errors++;
            $display("FAIL deep_underflow_latency: got %0d, want 77", lat);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        int bad;
        apply_op(10'd5, 25'h1800000, 1'b1, 1'b1, 1'b0);
        // New operand presented while DONE must be ignored.
        e_in = 10'd77; m_in = 25'h0000005; guard_in = 1'b1; round_in = 1'b1; sticky_in = 1'b1;
        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || z_e_out !== 10'd6 ||
                z_m_out !== 27'h0C00000 || {guard_out, round_out, sticky_out} !== 3'b011) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: %0d unstable cycles of 5, want 0 (last e=%h m=%h v=%b rdy=%b)",
                     bad, z_e_out, z_m_out, out_valid, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_to_idle: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        e_in = 10'd0; m_in = 25'h0000001; guard_in = 1'b0; round_in = 1'b1; sticky_in = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || z_m_out !== 27'h0) begin
            errors++;
            $display("FAIL reset_mid: out_valid=%b in_ready=%b m=%h, want 0/1/0", out_valid, in_ready, z_m_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_no_partial: out_valid seen %0d cycles, want 0", seen);
        end
        apply_op(10'd0, 25'h0000001, 1'b0, 1'b1, 1'b0);
        checks++;
        if (o_e !== 10'h3E9 || o_m !== 27'h0A00000 || {o_g, o_r, o_s} !== 3'b000 || lat !== 26) begin
            errors++;
            $display("FAIL after_reset_op: e=%h m=%h grs=%b%b%b lat=%0d, want e=3e9 m=a00000 grs=000 lat=26",
                     o_e, o_m, o_g, o_r, o_s, lat);
        end
        release_result();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        e_in = '0; m_in = '0; guard_in = 1'b0; round_in = 1'b0; sticky_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_left_one();
        test_carry();
        test_subnormal_right();
        test_zero();
        test_emin_stop();
        test_deep_underflow();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
